// File: rtl/fp6_addition_aligner.sv
// Pre-addition exponent aligner for LANES-wide FP6 E2M3 operand pairs, valid/ready on both sides.
// Define FP6_ALIGN_OUT_REG_EN for a 2-stage pipeline (compare, then shift); default is 1 stage.
module fp6_addition_aligner #(
    parameter int LANES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [6*LANES-1:0]   in_a,
    input  logic [6*LANES-1:0]   in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*LANES-1:0]   out_e,
    output logic [6*LANES-1:0]   out_ma,
    output logic [6*LANES-1:0]   out_mb,
    output logic [LANES-1:0]     out_sa,
    output logic [LANES-1:0]     out_sb,
    output logic [LANES-1:0]     out_sub,
    output logic [LANES-1:0]     out_swap
);

    typedef struct packed {
        logic [1:0] e;
        logic [3:0] m_large;
        logic [3:0] m_small;
        logic [1:0] diff;
        logic       sa;
        logic       sb;
        logic       sub;
        logic       swap;
    } pre_t;

    // Subnormals (e==0) take effective exponent 1; magnitude orders by {eff_e, mant4}.
    function automatic pre_t order_lane(input logic [5:0] a, input logic [5:0] b);
        pre_t       r;
        logic [1:0] ea;
        logic [1:0] eb;
        logic [3:0] ma;
        logic [3:0] mb;
        logic       b_larger;
        ea       = (a[4:3] == 2'd0) ? 2'd1 : a[4:3];
        eb       = (b[4:3] == 2'd0) ? 2'd1 : b[4:3];
        ma       = {|a[4:3], a[2:0]};
        mb       = {|b[4:3], b[2:0]};
        b_larger = {eb, mb} > {ea, ma};
        r.swap    = b_larger;
        r.e       = b_larger ? eb : ea;
        r.m_large = b_larger ? mb : ma;
        r.m_small = b_larger ? ma : mb;
        r.diff    = b_larger ? (eb - ea) : (ea - eb);
        r.sa      = b_larger ? b[5] : a[5];
        r.sb      = b_larger ? a[5] : b[5];
        r.sub     = a[5] ^ b[5];
        return r;
    endfunction

    // Two guard bits make the shift exact for diff <= 2.
    function automatic logic [5:0] shift_small(input pre_t p);
        return {p.m_small, 2'b00} >> p.diff;
    endfunction

    pre_t [LANES-1:0] pre_d;
    pre_t [LANES-1:0] out_src;
    logic             in_fire;
    logic             load_out;
    logic             valid_q;

    logic [2*LANES-1:0] out_e_d,    out_e_q;
    logic [6*LANES-1:0] out_ma_d,   out_ma_q;
    logic [6*LANES-1:0] out_mb_d,   out_mb_q;
    logic [LANES-1:0]   out_sa_d,   out_sa_q;
    logic [LANES-1:0]   out_sb_d,   out_sb_q;
    logic [LANES-1:0]   out_sub_d,  out_sub_q;
    logic [LANES-1:0]   out_swap_d, out_swap_q;

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            pre_d[i] = order_lane(in_a[6*i +: 6], in_b[6*i +: 6]);
        end
    end

`ifdef FP6_ALIGN_OUT_REG_EN
    logic             s0_valid_q;
    pre_t [LANES-1:0] s0_pre_q;
    logic             ready1;

    assign ready1   = !valid_q || out_ready;
    assign in_ready = !s0_valid_q || ready1;
    assign in_fire  = in_valid && in_ready;
    assign load_out = s0_valid_q && ready1;
    assign out_src  = s0_pre_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_valid_q <= 1'b0;
            s0_pre_q   <= '0;
        end else begin
            if (in_ready) s0_valid_q <= in_valid;
            if (in_fire)  s0_pre_q   <= pre_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
        end else if (ready1) begin
            valid_q <= s0_valid_q;
        end
    end
`else
    assign in_ready = !valid_q || out_ready;
    assign in_fire  = in_valid && in_ready;
    assign load_out = in_fire;
    assign out_src  = pre_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
        end else if (in_ready) begin
            valid_q <= in_valid;
        end
    end
`endif

    always_comb begin
        out_e_d    = '0;
        out_ma_d   = '0;
        out_mb_d   = '0;
        out_sa_d   = '0;
        out_sb_d   = '0;
        out_sub_d  = '0;
        out_swap_d = '0;
        for (int i = 0; i < LANES; i++) begin
            out_e_d[2*i +: 2]  = out_src[i].e;
            out_ma_d[6*i +: 6] = {out_src[i].m_large, 2'b00};
            out_mb_d[6*i +: 6] = shift_small(out_src[i]);
            out_sa_d[i]        = out_src[i].sa;
            out_sb_d[i]        = out_src[i].sb;
            out_sub_d[i]       = out_src[i].sub;
            out_swap_d[i]      = out_src[i].swap;
        end
    end

    // NOTE: output data is reset too, so a reset mid-stall visibly clears out_* at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_e_q    <= '0;
            out_ma_q   <= '0;
            out_mb_q   <= '0;
            out_sa_q   <= '0;
            out_sb_q   <= '0;
            out_sub_q  <= '0;
            out_swap_q <= '0;
        end else if (load_out) begin
            out_e_q    <= out_e_d;
            out_ma_q   <= out_ma_d;
            out_mb_q   <= out_mb_d;
            out_sa_q   <= out_sa_d;
            out_sb_q   <= out_sb_d;
            out_sub_q  <= out_sub_d;
            out_swap_q <= out_swap_d;
        end
    end

    assign out_valid = valid_q;
    assign out_e     = out_e_q;
    assign out_ma    = out_ma_q;
    assign out_mb    = out_mb_q;
    assign out_sa    = out_sa_q;
    assign out_sb    = out_sb_q;
    assign out_sub   = out_sub_q;
    assign out_swap  = out_swap_q;

endmodule

// File: tb/tb_fp6_addition_aligner.sv
// Scoreboard bench for fp6_addition_aligner: directed beats, backpressure, throughput, reset mid-stall.
module tb_fp6_addition_aligner;
    localparam int LANES = 4;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid;
    logic                 in_ready;
    logic [6*LANES-1:0]   in_a, in_b;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*LANES-1:0]   out_e;
    logic [6*LANES-1:0]   out_ma, out_mb;
    logic [LANES-1:0]     out_sa, out_sb, out_sub, out_swap;

    always #5 clk = ~clk;

    fp6_addition_aligner #(.LANES(LANES)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_e(out_e), .out_ma(out_ma), .out_mb(out_mb),
        .out_sa(out_sa), .out_sb(out_sb), .out_sub(out_sub), .out_swap(out_swap)
    );

    typedef struct packed {
        logic [2*LANES-1:0] e;
        logic [6*LANES-1:0] ma;
        logic [6*LANES-1:0] mb;
        logic [LANES-1:0]   sa;
        logic [LANES-1:0]   sb;
        logic [LANES-1:0]   sub;
        logic [LANES-1:0]   swap;
    } beat_t;

    beat_t sb_q[$];
    int    out_cycles[$];
    int    tests = 0;
    int    fails = 0;
    int    cyc = 0;
    beat_t override_exp;
    bit    use_override = 0;
    bit    last_in_ready;
    bit    last_out_valid;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: order by real magnitude value mant4 * 2^(eff_e-1).
    function automatic beat_t model(input logic [6*LANES-1:0] a, input logic [6*LANES-1:0] b);
        beat_t r = '0;
        for (int i = 0; i < LANES; i++) begin
            logic [5:0] la, lb;
            int ea, eb, ma4, mb4, va, vb, el, es, ml, ms;
            bit sw;
            la  = a[6*i +: 6];
            lb  = b[6*i +: 6];
            ea  = (la[4:3] == 2'd0) ? 1 : int'(la[4:3]);
            eb  = (lb[4:3] == 2'd0) ? 1 : int'(lb[4:3]);
            ma4 = int'(la[2:0]) + ((la[4:3] != 2'd0) ? 8 : 0);
            mb4 = int'(lb[2:0]) + ((lb[4:3] != 2'd0) ? 8 : 0);
            va  = ma4 << (ea - 1);
            vb  = mb4 << (eb - 1);
            sw  = (vb > va);
            el  = sw ? eb : ea;
            es  = sw ? ea : eb;
            ml  = sw ? mb4 : ma4;
            ms  = sw ? ma4 : mb4;
            r.e[2*i +: 2]  = 2'(el);
            r.ma[6*i +: 6] = 6'(ml * 4);
            r.mb[6*i +: 6] = 6'((ms * 4) >> (el - es));
            r.sa[i]        = sw ? lb[5] : la[5];
            r.sb[i]        = sw ? la[5] : lb[5];
            r.sub[i]       = la[5] ^ lb[5];
            r.swap[i]      = sw;
        end
        return r;
    endfunction

    // Called at a negedge with inputs already driven; resolves the upcoming posedge.
    task automatic cycle(output bit acc);
        #1;
        last_in_ready  = in_ready;
        last_out_valid = out_valid;
        if (out_valid) begin
            check("stale_beat", 64'(sb_q.size() != 0), 64'd1);
            if (sb_q.size() != 0) begin
                check("out_e",    64'(out_e),    64'(sb_q[0].e));
                check("out_ma",   64'(out_ma),   64'(sb_q[0].ma));
                check("out_mb",   64'(out_mb),   64'(sb_q[0].mb));
                check("out_sa",   64'(out_sa),   64'(sb_q[0].sa));
                check("out_sb",   64'(out_sb),   64'(sb_q[0].sb));
                check("out_sub",  64'(out_sub),  64'(sb_q[0].sub));
                check("out_swap", 64'(out_swap), 64'(sb_q[0].swap));
                if (out_ready) begin
                    void'(sb_q.pop_front());
                    out_cycles.push_back(cyc);
                end
            end
        end
        acc = in_valid && in_ready;
        if (acc) begin
            sb_q.push_back(use_override ? override_exp : model(in_a, in_b));
            use_override = 0;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain(input int budget);
        bit acc;
        in_valid = 1'b0;
        for (int i = 0; i < budget && sb_q.size() != 0; i++) cycle(acc);
        check("drain_timeout", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        bit acc;
        logic [6*LANES-1:0] bp_a[6];
        logic [6*LANES-1:0] bp_b[6];
        int sent;

        in_valid = 1'b0; out_ready = 1'b1; in_a = '0; in_b = '0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_e",     64'(out_e),     64'd0);
        check("rst_out_ma",    64'(out_ma),    64'd0);
        check("rst_out_mb",    64'(out_mb),    64'd0);
        check("rst_flags",     64'({out_sa, out_sb, out_sub, out_swap}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);

        // Directed beat: diff 2, subnormal vs normal, equal magnitude opposite sign, zero vs max.
        in_a = {6'b000000, 6'b110000, 6'b000011, 6'b011010};
        in_b = {6'b111111, 6'b010000, 6'b001000, 6'b001100};
        override_exp.e    = {2'd3, 2'd2, 2'd1, 2'd3};
        override_exp.ma   = {6'b111100, 6'b100000, 6'b100000, 6'b101000};
        override_exp.mb   = {6'b000000, 6'b100000, 6'b001100, 6'b001100};
        override_exp.sa   = 4'b1100;
        override_exp.sb   = 4'b0000;
        override_exp.sub  = 4'b1100;
        override_exp.swap = 4'b1010;
        use_override = 1;
        in_valid = 1'b1;
        cycle(acc);
        check("directed_accept", 64'(acc), 64'd1);
        drain(20);

        // Random beats back to back.
        for (int i = 0; i < 6; i++) begin
            in_a = 24'($urandom); in_b = 24'($urandom); in_valid = 1'b1;
            cycle(acc);
        end
        drain(20);

        // Backpressure: 6 beats, out_ready low for 3 cycles mid-stream.
        for (int i = 0; i < 6; i++) begin
            bp_a[i] = 24'($urandom);
            bp_b[i] = 24'($urandom);
        end
        sent = 0;
        for (int c = 0; c < 40 && sent < 6; c++) begin
            out_ready = !(c >= 3 && c < 6);
            in_valid  = 1'b1;
            in_a      = bp_a[sent];
            in_b      = bp_b[sent];
            cycle(acc);
            if (acc) sent++;
            if (c == 5) check("bp_full_in_ready", 64'(last_in_ready), 64'd0);
        end
        check("bp_all_sent", 64'(sent), 64'd6);
        out_ready = 1'b1;
        drain(20);

        // Throughput: 8 consecutive accepts, 8 consecutive outputs.
        out_cycles.delete();
        for (int i = 0; i < 8; i++) begin
            in_a = 24'($urandom); in_b = 24'($urandom); in_valid = 1'b1;
            cycle(acc);
            check("tput_accept", 64'(acc), 64'd1);
        end
        drain(20);
        check("tput_count", 64'(out_cycles.size()), 64'd8);
        if (out_cycles.size() == 8)
            check("tput_span", 64'(out_cycles[7] - out_cycles[0]), 64'd7);

        // Reset while stalled with a valid output.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_a = 24'($urandom); in_b = 24'($urandom); in_valid = 1'b1;
            cycle(acc);
        end
        #1;
        check("stall_out_valid", 64'(out_valid), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out_e",     64'(out_e),     64'd0);
        check("midrst_out_ma",    64'(out_ma),    64'd0);
        check("midrst_out_mb",    64'(out_mb),    64'd0);
        check("midrst_flags",     64'({out_sa, out_sb, out_sub, out_swap}), 64'd0);
        sb_q.delete();
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle(acc);
            if (i == 0) check("post_rst_in_ready", 64'(last_in_ready), 64'd1);
            check("post_rst_no_beat", 64'(last_out_valid), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
